// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port, shared by the ALU (A)
// and memory-load (B) writebacks, plus a busy scoreboard for issue-stage hazards.
module regfile_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int SELW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [SELW-1:0]  a_sel,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [SELW-1:0]  b_sel,
  input  logic [WIDTH-1:0] b_data,
  output logic             rf_write_en,
  output logic [SELW-1:0]  rf_sel_in,
  output logic [WIDTH-1:0] rf_in,
  input  logic             rsv_valid,
  input  logic [SELW-1:0]  rsv_sel,
  output logic             rsv_ready,
  input  logic [SELW-1:0]  rd_sel1,
  input  logic [SELW-1:0]  rd_sel2,
  output logic             rd_stall,
  output logic [NREGS-1:0] busy
);

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  logic             last_grant;
  logic             wen_q;
  logic [NREGS-1:0] busy_next;
  logic             a_xfer;
  logic             b_xfer;

  function automatic logic [SELW-1:0] to_idx(input logic [SELW-1:0] s);
    return SELW'(32'(s) % NREGS);
  endfunction

  // On a tie the requester that did not win last time gets the port.
  assign a_ready = !rst && a_valid && (!b_valid || last_grant == GRANT_B);
  assign b_ready = !rst && b_valid && (!a_valid || last_grant == GRANT_A);
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  // Masking with rst drops an accepted write that would otherwise land on a reset edge.
  assign rf_write_en = wen_q && !rst;

  assign rsv_ready = !rst && !busy[to_idx(rsv_sel)];
  assign rd_stall  = busy[to_idx(rd_sel1)] | busy[to_idx(rd_sel2)];

  // A new reservation overrides a writeback clear of the same register.
  always_comb begin
    busy_next = busy;
    if (rf_write_en)
      busy_next[rf_sel_in] = 1'b0;
    if (rsv_valid && rsv_ready)
      busy_next[to_idx(rsv_sel)] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q      <= 1'b0;
      rf_sel_in  <= '0;
      rf_in      <= '0;
      busy       <= '0;
      last_grant <= GRANT_B;
    end else begin
      wen_q <= a_xfer || b_xfer;
      busy  <= busy_next;
      if (a_xfer) begin
        rf_sel_in  <= to_idx(a_sel);
        rf_in      <= a_data;
        last_grant <= GRANT_A;
      end else if (b_xfer) begin
        rf_sel_in  <= to_idx(b_sel);
        rf_in      <= b_data;
        last_grant <= GRANT_B;
      end
    end
  end

endmodule
